// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform generator: envelope stage encoding.
package wavegen_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE    = 3'd0,
        STAGE_ATTACK  = 3'd1,
        STAGE_DECAY   = 3'd2,
        STAGE_SUSTAIN = 3'd3,
        STAGE_RELEASE = 3'd4
    } stageT;

endpackage

// File: rtl/adsr_envelope_if.sv
// Control and status bundle between the envelope generator and its user.
interface adsr_envelope_if
    import wavegen_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic                   tick;
    logic                   trigger;
    logic                   noteRelease;
    logic [WIDTH-1:0]       attackStep;
    logic [WIDTH-1:0]       decayStep;
    logic [WIDTH-1:0]       sustainLevel;
    logic [WIDTH-1:0]       releaseStep;
    logic [WIDTH-1:0]       level;
    logic [STAGE_WIDTH-1:0] stage;
    logic                   active;
    logic                   done;

    modport master (
        output tick, trigger, noteRelease, attackStep, decayStep, sustainLevel, releaseStep,
        input  level, stage, active, done
    );

    modport slave (
        input  tick, trigger, noteRelease, attackStep, decayStep, sustainLevel, releaseStep,
        output level, stage, active, done
    );

endinterface

// File: rtl/rising_edge_detect.sv
// Single-cycle rise detector for pulses that may be stretched over several cycles.
module rising_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev_r;

    // Previous sample; cleared on reset so an input already high counts as an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= in;
        end
    end

    assign rise = in & ~prev_r;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: steps a saturating amplitude level once per sample tick,
// driven by edge-detected note-on / note-off pulses.
module adsr_envelope
    import wavegen_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic            clock,
    input logic            reset,
    adsr_envelope_if.slave bus
);

    localparam logic [WIDTH-1:0] LEVEL_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LEVEL_ZERO = {WIDTH{1'b0}};

    logic             trigRise_s;
    logic             relRise_s;
    stageT            stage_r;
    logic [WIDTH-1:0] level_r;
    logic             active_r;
    logic             done_r;
    logic [WIDTH:0]   attackSum_s;
    logic [WIDTH:0]   decayDiff_s;
    logic [WIDTH:0]   releaseDiff_s;
    logic             attackFull_s;
    logic             decayFull_s;
    logic             releaseEmpty_s;

    rising_edge_detect trigDetect (
        .clock (clock),
        .reset (reset),
        .in    (bus.trigger),
        .rise  (trigRise_s)
    );

    rising_edge_detect relDetect (
        .clock (clock),
        .reset (reset),
        .in    (bus.noteRelease),
        .rise  (relRise_s)
    );

    // One extra bit carries overflow / borrow so every bound saturates instead of wrapping
    always_comb begin
        attackSum_s    = {1'b0, level_r} + {1'b0, bus.attackStep};
        decayDiff_s    = {1'b0, level_r} - {1'b0, bus.decayStep};
        releaseDiff_s  = {1'b0, level_r} - {1'b0, bus.releaseStep};
        attackFull_s   = (attackSum_s >= {1'b0, LEVEL_MAX}) || (bus.attackStep == LEVEL_ZERO);
        decayFull_s    = decayDiff_s[WIDTH] || (decayDiff_s[WIDTH-1:0] <= bus.sustainLevel)
                         || (bus.decayStep == LEVEL_ZERO);
        releaseEmpty_s = releaseDiff_s[WIDTH] || (releaseDiff_s[WIDTH-1:0] == LEVEL_ZERO)
                         || (bus.releaseStep == LEVEL_ZERO);
    end

    // Envelope FSM: edge events pre-empt the tick step for that cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_r  <= STAGE_IDLE;
            level_r  <= LEVEL_ZERO;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (trigRise_s) begin
                stage_r  <= STAGE_ATTACK;
                active_r <= 1'b1;
            end else if (relRise_s && (stage_r inside {STAGE_ATTACK, STAGE_DECAY, STAGE_SUSTAIN})) begin
                stage_r <= STAGE_RELEASE;
            end else if (bus.tick) begin
                case (stage_r)
                    STAGE_ATTACK: begin
                        if (attackFull_s) begin
                            level_r <= LEVEL_MAX;
                            stage_r <= STAGE_DECAY;
                        end else begin
                            level_r <= attackSum_s[WIDTH-1:0];
                        end
                    end
                    STAGE_DECAY: begin
                        if (decayFull_s) begin
                            level_r <= bus.sustainLevel;
                            stage_r <= STAGE_SUSTAIN;
                        end else begin
                            level_r <= decayDiff_s[WIDTH-1:0];
                        end
                    end
                    STAGE_SUSTAIN: begin
                        level_r <= bus.sustainLevel;
                    end
                    STAGE_RELEASE: begin
                        if (releaseEmpty_s) begin
                            level_r  <= LEVEL_ZERO;
                            stage_r  <= STAGE_IDLE;
                            active_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            level_r <= releaseDiff_s[WIDTH-1:0];
                        end
                    end
                    STAGE_IDLE: begin
                        level_r <= LEVEL_ZERO;
                    end
                    default: begin
                        level_r  <= LEVEL_ZERO;
                        stage_r  <= STAGE_IDLE;
                        active_r <= 1'b0;
                    end
                endcase
            end else begin
                level_r <= level_r;
            end
        end
    end

    assign bus.level  = level_r;
    assign bus.stage  = stage_r;
    assign bus.active = active_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: expected output changes are queued by the
// stimulus and popped by a monitor each time level/stage/done change.
module tb_adsr_envelope;

    localparam int WIDTH = 8;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    typedef struct packed {
        logic [7:0] lvl;
        logic [2:0] stg;
        logic       dn;
    } expT;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    expT   expQ[$];
    int    checks  = 0;
    int    fails   = 0;
    int    cyc     = 0;
    int    doneRun = 0;
    logic  monOn   = 1'b0;
    logic [11:0] prevSample = 12'd0;

    adsr_envelope_if #(.WIDTH(WIDTH)) bus ();

    adsr_envelope #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Advance one clock; tick is high on every 4th sampled cycle
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        bus.tick = ((cyc % 4) == 3);
    endtask

    task automatic toTick();
        step();
        while (bus.tick !== 1'b1) step();
    endtask

    task automatic push(input logic [7:0] l, input logic [2:0] s, input logic d);
        expT e;
        e.lvl = l;
        e.stg = s;
        e.dn  = d;
        expQ.push_back(e);
    endtask

    task automatic drain(input string name, input int maxCycles);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            step();
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected changes never seen, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic pulseRelease();
        bus.noteRelease = 1'b1;
        step();
        bus.noteRelease = 1'b0;
    endtask

    // Monitor: every change of the observed outputs consumes one expected entry
    initial begin
        logic [11:0] cur;
        expT         e;
        forever begin
            @(negedge clock);
            if (monOn) begin
                cur = {bus.level, bus.stage, bus.done};
                if (cur !== prevSample) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected change: level=%0d stage=%0d done=%0b, required no change",
                                 bus.level, bus.stage, bus.done);
                    end else begin
                        e = expQ.pop_front();
                        if (bus.level !== e.lvl || bus.stage !== e.stg || bus.done !== e.dn
                            || bus.active !== (e.stg != S_IDLE)) begin
                            fails++;
                            $display("FAIL envelope step: got level=%0d stage=%0d active=%0b done=%0b, required level=%0d stage=%0d active=%0b done=%0b",
                                     bus.level, bus.stage, bus.active, bus.done,
                                     e.lvl, e.stg, (e.stg != S_IDLE), e.dn);
                        end
                    end
                    prevSample = cur;
                end
                if (bus.done === 1'b1) begin
                    doneRun++;
                end else if (doneRun != 0) begin
                    checks++;
                    if (doneRun != 1) begin
                        fails++;
                        $display("FAIL done width: got %0d cycles, required 1", doneRun);
                    end
                    doneRun = 0;
                end
            end
        end
    end

    initial begin
        bus.tick         = 1'b0;
        bus.trigger      = 1'b0;
        bus.noteRelease  = 1'b0;
        bus.attackStep   = 8'd0;
        bus.decayStep    = 8'd0;
        bus.sustainLevel = 8'd0;
        bus.releaseStep  = 8'd0;
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.level !== 8'd0 || bus.stage !== S_IDLE || bus.active !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset state: got level=%0d stage=%0d active=%0b done=%0b, required all 0",
                     bus.level, bus.stage, bus.active, bus.done);
        end
        reset = 1'b0;
        prevSample = {bus.level, bus.stage, bus.done};
        monOn = 1'b1;

        // Full note; trigger held 10 cycles, its edge on a tick cycle
        bus.attackStep   = 8'd64;
        bus.decayStep    = 8'd32;
        bus.sustainLevel = 8'd128;
        bus.releaseStep  = 8'd64;
        push(8'd0,   S_ATTACK,  1'b0);
        push(8'd64,  S_ATTACK,  1'b0);
        push(8'd128, S_ATTACK,  1'b0);
        push(8'd192, S_ATTACK,  1'b0);
        push(8'd255, S_DECAY,   1'b0);
        push(8'd223, S_DECAY,   1'b0);
        push(8'd191, S_DECAY,   1'b0);
        push(8'd159, S_DECAY,   1'b0);
        push(8'd128, S_SUSTAIN, 1'b0);
        toTick();
        bus.trigger = 1'b1;
        repeat (10) step();
        bus.trigger = 1'b0;
        drain("full note attack/decay", 100);
        push(8'd128, S_RELEASE, 1'b0);
        push(8'd64,  S_RELEASE, 1'b0);
        push(8'd0,   S_IDLE,    1'b1);
        push(8'd0,   S_IDLE,    1'b0);
        bus.noteRelease = 1'b1;
        repeat (3) step();
        bus.noteRelease = 1'b0;
        drain("full note release", 100);

        // Retrigger from RELEASE at level 100 continues upward
        bus.attackStep   = 8'd50;
        bus.decayStep    = 8'd0;
        bus.sustainLevel = 8'd20;
        bus.releaseStep  = 8'd30;
        push(8'd0,   S_ATTACK, 1'b0);
        push(8'd50,  S_ATTACK, 1'b0);
        push(8'd100, S_ATTACK, 1'b0);
        toTick();
        step();
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        toTick();
        step();
        toTick();
        step();
        push(8'd100, S_RELEASE, 1'b0);
        push(8'd100, S_ATTACK,  1'b0);
        push(8'd164, S_ATTACK,  1'b0);
        push(8'd228, S_ATTACK,  1'b0);
        push(8'd255, S_DECAY,   1'b0);
        push(8'd20,  S_SUSTAIN, 1'b0);
        bus.noteRelease = 1'b1;
        step();
        bus.noteRelease = 1'b0;
        bus.trigger     = 1'b1;
        bus.attackStep  = 8'd64;
        step();
        bus.trigger = 1'b0;
        drain("retrigger", 100);
        push(8'd20, S_RELEASE, 1'b0);
        push(8'd0,  S_IDLE,    1'b1);
        push(8'd0,  S_IDLE,    1'b0);
        pulseRelease();
        drain("release saturates", 100);

        // Release edge in IDLE is ignored
        pulseRelease();
        repeat (6) step();
        checks++;
        if (bus.stage !== S_IDLE || bus.level !== 8'd0) begin
            fails++;
            $display("FAIL release in idle: got stage=%0d level=%0d, required stage=0 level=0",
                     bus.stage, bus.level);
        end

        // Simultaneous edges with all steps 0: trigger wins, one stage per tick
        bus.attackStep   = 8'd0;
        bus.decayStep    = 8'd0;
        bus.sustainLevel = 8'd128;
        bus.releaseStep  = 8'd0;
        push(8'd0,   S_ATTACK,  1'b0);
        push(8'd255, S_DECAY,   1'b0);
        push(8'd128, S_SUSTAIN, 1'b0);
        toTick();
        step();
        bus.trigger     = 1'b1;
        bus.noteRelease = 1'b1;
        step();
        bus.trigger     = 1'b0;
        bus.noteRelease = 1'b0;
        drain("zero steps", 100);
        push(8'd100, S_SUSTAIN, 1'b0);
        bus.sustainLevel = 8'd100;
        drain("sustain tracking", 100);
        push(8'd100, S_RELEASE, 1'b0);
        push(8'd0,   S_IDLE,    1'b1);
        push(8'd0,   S_IDLE,    1'b0);
        pulseRelease();
        drain("zero release", 100);

        // Reset in DECAY at level 200, trigger already high as reset drops
        bus.attackStep   = 8'd100;
        bus.decayStep    = 8'd55;
        bus.sustainLevel = 8'd50;
        bus.releaseStep  = 8'd10;
        push(8'd0,   S_ATTACK, 1'b0);
        push(8'd100, S_ATTACK, 1'b0);
        push(8'd200, S_ATTACK, 1'b0);
        push(8'd255, S_DECAY,  1'b0);
        push(8'd200, S_DECAY,  1'b0);
        toTick();
        step();
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        drain("reach decay 200", 100);
        push(8'd0,   S_IDLE,    1'b0);
        push(8'd0,   S_ATTACK,  1'b0);
        push(8'd100, S_ATTACK,  1'b0);
        push(8'd200, S_ATTACK,  1'b0);
        push(8'd255, S_DECAY,   1'b0);
        push(8'd200, S_DECAY,   1'b0);
        push(8'd145, S_DECAY,   1'b0);
        push(8'd90,  S_DECAY,   1'b0);
        push(8'd50,  S_SUSTAIN, 1'b0);
        reset       = 1'b1;
        bus.trigger = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        bus.trigger = 1'b0;
        drain("reset mid-envelope", 200);

        repeat (12) step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Slow-domain ADSR envelope generator consuming the note-on and note-off pulses re-timed by the fast-to-slow pulse crosser. Each pulse may be stretched over more than one slow cycle, so the block edge-detects it. It steps an unsigned amplitude level once per sample tick through attack, decay, sustain and release. The level feeds the oscillator's output multiplier.

## Interface
- `WIDTH`, default 16: bit width of the level, the step inputs and `sustainLevel`.
- `clock`  in  1  slow-domain clock; the only clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  sample strobe; the level updates only on cycles where it is high.
- `trigger`  in  1  note-on pulse from the crosser; only its rising edge acts.
- `release`  in  1  note-off pulse from the crosser; only its rising edge acts.
- `attackStep`  in  WIDTH  increment per tick during attack.
- `decayStep`  in  WIDTH  decrement per tick during decay.
- `sustainLevel`  in  WIDTH  sustain target.
- `releaseStep`  in  WIDTH  decrement per tick during release.
- `level`  out  WIDTH  current envelope amplitude.
- `stage`  out  3  current state encoding.
- `active`  out  1  high when `stage` is not IDLE.
- `done`  out  1  one-cycle pulse when release reaches 0.

## Operation
- Stage encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. MAX is 2^WIDTH−1.
- Edge detect:
  - `trigRise = trigger & ~trigPrev`; `relRise = release & ~relPrev`.
  - Both `*Prev` registers reset to 0, so an input already high on the first cycle after reset counts as an edge.
- Events are evaluated every cycle, independent of `tick`. Priority is reset > `trigRise` > `relRise` > tick step.
  - `trigRise`, any stage: go to ATTACK, level unchanged. A retrigger continues from the current level; it does not restart from 0.
  - `relRise` in ATTACK, DECAY or SUSTAIN: go to RELEASE, level unchanged.
  - `relRise` in IDLE or RELEASE: ignored.
  - Both edges in the same cycle: `trigRise` wins and `relRise` is dropped.
- Tick step, only on a `tick` cycle with no event:
  - ATTACK: compute `level + attackStep` in WIDTH+1 bits.
    - If the sum is ≥ MAX, or `attackStep` is 0: level = MAX, go to DECAY.
    - Otherwise level = sum.
  - DECAY: compute `level − decayStep` in WIDTH+1 signed bits.
    - If the result is ≤ `sustainLevel`, or `decayStep` is 0: level = `sustainLevel`, go to SUSTAIN.
    - Otherwise level = result.
  - SUSTAIN: level = `sustainLevel`, so live changes are tracked on each tick.
  - RELEASE: compute `level − releaseStep`.
    - If the result is ≤ 0, or `releaseStep` is 0: level = 0, go to IDLE, assert `done`.
    - Otherwise level = result.
  - IDLE: level holds at 0.
- Step value 0 means the stage completes instantly on the next tick; it never stalls.
- Arithmetic never wraps; every bound saturates.
- `sustainLevel` above the level at DECAY entry: DECAY completes on its first tick and level jumps to `sustainLevel`.

## Timing
- Reset values: `level`=0, `stage`=IDLE, `active`=0, `done`=0, `trigPrev`=`relPrev`=0.
- Reset asserted mid-envelope: all of the above apply on the next edge, with no `done` pulse.
- An edge sampled in cycle N makes `stage` change in cycle N+1. On cycle N itself the level does not step, even if `tick`=1.
- The first level step is on the first `tick` cycle after the stage change.
- `done` is high exactly one cycle: the cycle after the tick that zeroed the level, together with `stage`=IDLE.
- An input held high for any number of cycles produces exactly one edge.

## Structure
- Shared package `wavegen_pkg` holds the stage encoding constants (`STAGE_IDLE` … `STAGE_RELEASE`) and the stage width of 3.
- Sub-module `rising_edge_detect` (clock, reset, in, rise) is instantiated twice.
- The FSM and the datapath live in this module.

## Test plan
Bench parameters: WIDTH=8, `tick` every 4th cycle.
- Full note: attack=64, decay=32, sustain=128, release=64.
  - Levels per tick: 64, 128, 192, 255 (attack, saturated), then 223, 191, 159, 128 (decay), then sustain.
  - After a release edge: 64, 0, with `done` pulsing once.
- Trigger held high for 10 cycles gives a single ATTACK entry. A `tick` coinciding with the edge cycle leaves the level at 0 for that tick.
- Retrigger in RELEASE at level 100: next attack tick gives 164, not 64.
- Trigger and release edges in the same cycle: `stage` goes to ATTACK and the release is ignored. A release edge in IDLE leaves `stage`=0.
- All steps 0:
  - Trigger, then level goes 255, then 128, one stage per tick.
  - After a release edge: 0 on the next tick, with `done`.
- Reset in DECAY at level 200: next cycle `level`=0, `stage`=0, `done`=0. A trigger already high when reset drops starts ATTACK.
